sync_filter_edge: RTL and testbench

- Multi-channel successor to the single-bit synchronizer.
- Brings WIDTH asynchronous inputs into the `clk` domain through a parametrised flop chain.
- Each channel then has a stable-count glitch filter and registered rise/fall event pulses.
- Sits at the chip boundary in front of button, status and handshake inputs that feed the control FSMs.

---
 rtl/sync_filter_edge.sv | 129 ++++++++++++
 tb/tb_sync_filter_edge.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_filter_edge.sv
// Multi-channel input conditioner: a synchronizer chain, a stable-count glitch filter and registered rise/fall pulses.
// Optional sticky event flags are enabled with `define SYNC_FILTER_STICKY_EN.
module sync_filter_edge #(
  parameter int              WIDTH      = 4,
  parameter int              STAGES     = 2,
  parameter logic [WIDTH-1:0] RST_VAL   = {WIDTH{1'b1}},
  parameter int              FILTER_CNT = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] filt_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
`ifdef SYNC_FILTER_STICKY_EN
  ,
  input  logic [WIDTH-1:0] clr_sticky,
  output logic [WIDTH-1:0] sticky_rise,
  output logic [WIDTH-1:0] sticky_fall
`endif
);

  localparam int               CNT_W   = $clog2(FILTER_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] filt_q;
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic [WIDTH-1:0] sync_s;

  assign sync_s = sync_q[STAGES-1];

  // Pure shift chain: no logic between synchronizer stages.
  always_comb begin
    sync_d[0] = async_in;
    for (int k = 1; k < STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Per-channel filter: a mismatch must persist FILTER_CNT cycles before filt_out accepts it.
  always_comb begin
    filt_d = filt_q;
    rise_d = {WIDTH{1'b0}};
    fall_d = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_s[i] == filt_q[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]  = {CNT_W{1'b0}};
        filt_d[i] = sync_s[i];
        rise_d[i] = sync_s[i];
        fall_d[i] = ~sync_s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= RST_VAL;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
      filt_q <= RST_VAL;
      rise_q <= {WIDTH{1'b0}};
      fall_q <= {WIDTH{1'b0}};
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sync_out = sync_s;
  assign filt_out = filt_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign changed  = |(rise_q | fall_q);

`ifdef SYNC_FILTER_STICKY_EN
  logic [WIDTH-1:0] sticky_rise_q;
  logic [WIDTH-1:0] sticky_rise_d;
  logic [WIDTH-1:0] sticky_fall_q;
  logic [WIDTH-1:0] sticky_fall_d;

  // Flags are set from the visible pulse, so a clear in the pulse cycle loses to the set.
  always_comb begin
    sticky_rise_d = rise_q | (sticky_rise_q & ~clr_sticky);
    sticky_fall_d = fall_q | (sticky_fall_q & ~clr_sticky);
  end

  // Sticky flag registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sticky_rise_q <= {WIDTH{1'b0}};
      sticky_fall_q <= {WIDTH{1'b0}};
    end else begin
      sticky_rise_q <= sticky_rise_d;
      sticky_fall_q <= sticky_fall_d;
    end
  end

  assign sticky_rise = sticky_rise_q;
  assign sticky_fall = sticky_fall_q;
`endif

endmodule

// File: tb/tb_sync_filter_edge.sv
// Directed bench for sync_filter_edge (WIDTH=4, STAGES=2, FILTER_CNT=4, RST_VAL=4'hF).
module tb_sync_filter_edge;

  localparam int WIDTH = 4;

  logic             clk;
  logic             n_rst;
  logic [WIDTH-1:0] async_in;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] filt_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;
  logic [WIDTH-1:0] clr_sticky;
`ifdef SYNC_FILTER_STICKY_EN
  logic [WIDTH-1:0] sticky_rise;
  logic [WIDTH-1:0] sticky_fall;
`endif

  int checks = 0;
  int errors = 0;

  sync_filter_edge #(
    .WIDTH(4), .STAGES(2), .RST_VAL(4'hF), .FILTER_CNT(4)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .async_in(async_in),
    .sync_out(sync_out),
    .filt_out(filt_out),
    .rise(rise),
    .fall(fall),
    .changed(changed)
`ifdef SYNC_FILTER_STICKY_EN
    ,
    .clr_sticky(clr_sticky),
    .sticky_rise(sticky_rise),
    .sticky_fall(sticky_fall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_rst      = 1'b0;
    async_in   = 4'h0;
    clr_sticky = 4'h0;

    // Reset
    step(2);
    check("rst_sync", sync_out, 4'hF);
    check("rst_filt", filt_out, 4'hF);
    check("rst_rise", rise, 4'h0);
    check("rst_fall", fall, 4'h0);
    check("rst_changed", {3'b000, changed}, 4'h0);
`ifdef SYNC_FILTER_STICKY_EN
    check("rst_sticky_rise", sticky_rise, 4'h0);
    check("rst_sticky_fall", sticky_fall, 4'h0);
`endif
    n_rst    = 1'b1;
    async_in = 4'hF;
    step(3);
    check("idle_filt", filt_out, 4'hF);
    check("idle_fall", fall, 4'h0);

    // Fall qualify on channel 0
    async_in = 4'hE;
    step(1);
    check("fq_sync_e1", sync_out, 4'hF);
    step(1);
    check("fq_sync_e2", sync_out, 4'hE);
    check("fq_filt_e2", filt_out, 4'hF);
    step(3);
    check("fq_filt_e5", filt_out, 4'hF);
    check("fq_fall_e5", fall, 4'h0);
    step(1);
    check("fq_filt_e6", filt_out, 4'hE);
    check("fq_fall_e6", fall, 4'h1);
    check("fq_rise_e6", rise, 4'h0);
    check("fq_changed_e6", {3'b000, changed}, 4'h1);
    step(1);
    check("fq_fall_e7", fall, 4'h0);
    check("fq_changed_e7", {3'b000, changed}, 4'h0);

    // Three-cycle glitch on channel 1
    async_in = 4'hC;
    step(2);
    check("gl_sync_e2", sync_out, 4'hC);
    step(1);
    check("gl_sync_e3", sync_out, 4'hC);
    async_in = 4'hE;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("gl_fall", fall, 4'h0);
      check("gl_filt", filt_out, 4'hE);
    end
    check("gl_sync_end", sync_out, 4'hE);

    // Reset dropped between edges acts only at the next posedge
    n_rst = 1'b0;
    #3;
    check("rd_sync_mid", sync_out, 4'hE);
    check("rd_filt_mid", filt_out, 4'hE);
    step(1);
    check("rd_sync", sync_out, 4'hF);
    check("rd_filt", filt_out, 4'hF);
    check("rd_fall", fall, 4'h0);
    check("rd_rise", rise, 4'h0);
    n_rst    = 1'b1;
    async_in = 4'h0;
    step(5);
    check("rq_filt_e5", filt_out, 4'hF);
    step(1);
    check("rq_filt_e6", filt_out, 4'h0);
    check("rq_fall_e6", fall, 4'hF);
    step(1);
    check("rq_fall_e7", fall, 4'h0);

    // Simultaneous rise on channels 0 and 2, later fall on channel 0
    async_in = 4'h5;
    step(4);
    async_in = 4'h4;
    step(1);
    check("sm_rise_e5", rise, 4'h0);
    check("sm_filt_e5", filt_out, 4'h0);
    step(1);
    check("sm_rise_e6", rise, 4'h5);
    check("sm_fall_e6", fall, 4'h0);
    check("sm_filt_e6", filt_out, 4'h5);
    step(3);
    check("sm_rise_e9", rise, 4'h0);
    check("sm_fall_e9", fall, 4'h0);
    check("sm_filt_e9", filt_out, 4'h5);
    step(1);
    check("sm_fall_e10", fall, 4'h1);
    check("sm_rise_e10", rise, 4'h0);
    check("sm_filt_e10", filt_out, 4'h4);

    // Reset in the middle of a qualification run
    n_rst    = 1'b0;
    async_in = 4'hE;
    step(1);
    check("rm_pre_filt", filt_out, 4'hF);
    check("rm_pre_fall", fall, 4'h0);
    check("rm_pre_rise", rise, 4'h0);
    n_rst = 1'b1;
    step(4);
    n_rst = 1'b0;
    step(1);
    check("rm_filt", filt_out, 4'hF);
    check("rm_fall", fall, 4'h0);
    check("rm_sync", sync_out, 4'hF);
    n_rst = 1'b1;
    step(5);
    check("rm_filt_e5", filt_out, 4'hF);
    check("rm_fall_e5", fall, 4'h0);
    step(1);
    check("rm_fall_e6", fall, 4'h1);
    check("rm_filt_e6", filt_out, 4'hE);

`ifdef SYNC_FILTER_STICKY_EN
    // Sticky flags
    async_in = 4'hA;
    step(6);
    check("st_fall2", fall, 4'h4);
    async_in = 4'hE;
    step(6);
    check("st_rise2", rise, 4'h4);
    step(1);
    check("st_sr_set", sticky_rise, 4'h4);
    check("st_sf_set", sticky_fall, 4'h4);
    async_in = 4'hA;
    step(6);
    async_in = 4'hE;
    step(6);
    check("st_rise2b", rise, 4'h4);
    clr_sticky = 4'h4;
    step(1);
    check("st_sr_setwins", sticky_rise, 4'h4);
    check("st_sf_clr", sticky_fall, 4'h0);
    clr_sticky = 4'h0;
    step(1);
    clr_sticky = 4'h4;
    step(1);
    check("st_sr_clr", sticky_rise, 4'h0);
    clr_sticky = 4'h0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
